// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared FSM encoding and elaboration helpers for the digit-serial adder
package adder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/digit_rca.sv
// rtl/digit_rca.sv - combinational N-bit ripple-carry slice
// Also exposes the carry into the top bit so the caller can form signed overflow.
module digit_rca #(
   parameter int N = 4
) (
   input  logic         ci,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   output logic         co,
   output logic [N-1:0] s,
   output logic         c_msb_in
);

   logic [N:0] c;

   assign c[0] = ci;

   for (genvar i = 0; i < N; i++) begin : g_bit
      assign s[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
   end

   assign co       = c[N];
   assign c_msb_in = c[N-1];

endmodule

// File: rtl/digit_serial_adder.sv
// rtl/digit_serial_adder.sv - multi-cycle add/subtract, DIGIT bits per clock, LSB digit first
// Ready/valid on both sides; result held in DONE until the consumer takes it.
module digit_serial_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             Sub,
   input  logic             Cin,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] S,
   output logic             Cout,
   output logic             Ovf
);

   localparam int NDIG = (DIGIT >= 1) ? WIDTH / DIGIT : 1;
   localparam int CW   = clog2(NDIG) + 1;
   localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

   if (DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_cfg
      $fatal(1, "digit_serial_adder: WIDTH must be a positive multiple of DIGIT");
   end

   state_t           state, state_nx;
   logic [WIDTH-1:0] a_q, b_q, s_q, s_nx;
   logic [CW-1:0]    cnt;
   logic             carry_q, cout_q, ovf_q;
   logic [DIGIT-1:0] sum_dig;
   logic             co_dig, cmsb_dig;

   // Operand registers shift right each RUN clock, so the active digit is always the low slice.
   digit_rca #(.N(DIGIT)) u_rca (
      .ci       (carry_q),
      .a        (a_q[DIGIT-1:0]),
      .b        (b_q[DIGIT-1:0]),
      .co       (co_dig),
      .s        (sum_dig),
      .c_msb_in (cmsb_dig)
   );

   always_comb begin
      s_nx = s_q;
      for (int d = 0; d < NDIG; d++) begin
         if (cnt == CW'(d)) s_nx[d*DIGIT +: DIGIT] = sum_dig;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (in_valid)     state_nx = RUN;
         RUN:     if (cnt == LAST)  state_nx = DONE;
         DONE:    if (out_ready)    state_nx = IDLE;
         default:                   state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q     <= '0;
         b_q     <= '0;
         s_q     <= '0;
         cnt     <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  // Subtraction as A + ~B + ~Cin: invert B and the incoming borrow up front.
                  a_q     <= A;
                  b_q     <= B ^ {WIDTH{Sub}};
                  carry_q <= Cin ^ Sub;
                  cnt     <= '0;
               end
            end
            RUN: begin
               a_q     <= a_q >> DIGIT;
               b_q     <= b_q >> DIGIT;
               s_q     <= s_nx;
               carry_q <= co_dig;
               cnt     <= cnt + CW'(1);
               if (cnt == LAST) begin
                  cout_q <= co_dig;
                  ovf_q  <= cmsb_dig ^ co_dig;
               end
            end
            default: ;
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign S         = s_q;
   assign Cout      = cout_q;
   assign Ovf       = ovf_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// tb/tb_digit_serial_adder.sv - scoreboard bench over DIGIT=4,1,8,16 instances sharing one stimulus stream
module tb_digit_serial_adder;

   typedef struct packed {
      logic [15:0] s;
      logic        cout;
      logic        ovf;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        sub = 1'b0;
   logic        cin = 1'b0;
   logic [15:0] a = '0;
   logic [15:0] b = '0;
   logic        out_ready = 1'b1;
   int          bp_mode = 0;
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;

   logic [3:0]       in_ready_v, out_valid_v, cout_v, ovf_v;
   logic [3:0][15:0] s_v;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      if (bp_mode == 0)      out_ready = 1'b1;
      else if (bp_mode == 1) out_ready = ($urandom % 3) != 0;
      else                   out_ready = 1'b0;
   end

   // Reference: plain integer arithmetic; overflow means the signed result leaves 16-bit range.
   function automatic exp_t model(input logic [15:0] av, input logic [15:0] bv,
                                  input logic sv, input logic cv);
      exp_t        m;
      int          sa, sb, ci, r;
      int unsigned ua, ub;
      sa = int'($signed(av));
      sb = int'($signed(bv));
      ua = av;
      ub = bv;
      ci = cv ? 1 : 0;
      if (!sv) begin
         r      = sa + sb + ci;
         m.s    = 16'(ua + ub + ci);
         m.cout = (ua + ub + ci) > 65535;
      end else begin
         r      = sa - sb - ci;
         m.s    = 16'(ua - ub - ci);
         m.cout = ua >= (ub + ci);
      end
      m.ovf = (r > 32767) || (r < -32768);
      return m;
   endfunction

   for (genvar gi = 0; gi < 4; gi++) begin : g
      localparam int D  = (gi == 0) ? 4 : (gi == 1) ? 1 : (gi == 2) ? 8 : 16;
      localparam int ND = 16 / D;
      exp_t q[$];
      logic vld_d = 1'b0;
      int   acc = 0;

      digit_serial_adder #(.WIDTH(16), .DIGIT(D)) u_dut (
         .clk       (clk),
         .rst_n     (rst_n),
         .in_valid  (in_valid),
         .in_ready  (in_ready_v[gi]),
         .Sub       (sub),
         .Cin       (cin),
         .A         (a),
         .B         (b),
         .out_valid (out_valid_v[gi]),
         .out_ready (out_ready),
         .S         (s_v[gi]),
         .Cout      (cout_v[gi]),
         .Ovf       (ovf_v[gi])
      );

      always @(negedge clk) begin
         if (!rst_n) begin
            q.delete();
            vld_d <= 1'b0;
         end else begin
            if (in_valid && in_ready_v[gi]) begin
               q.push_back(model(a, b, sub, cin));
               acc <= cyc + 1;
            end
            if (out_valid_v[gi] && !vld_d) begin
               checks++;
               if (cyc - acc != ND) begin
                  errors++;
                  $display("FAIL latency D=%0d got %0d want %0d", D, cyc - acc, ND);
               end
            end
            if (out_valid_v[gi]) begin
               checks++;
               if (in_ready_v[gi] !== 1'b0) begin
                  errors++;
                  $display("FAIL in_ready_in_done D=%0d got %b want 0", D, in_ready_v[gi]);
               end
               checks++;
               if (q.size() == 0) begin
                  errors++;
                  $display("FAIL unexpected_result D=%0d S=%h", D, s_v[gi]);
               end else begin
                  if ({s_v[gi], cout_v[gi], ovf_v[gi]} !== q[0]) begin
                     errors++;
                     $display("FAIL result D=%0d got S=%h C=%b V=%b want S=%h C=%b V=%b",
                              D, s_v[gi], cout_v[gi], ovf_v[gi], q[0].s, q[0].cout, q[0].ovf);
                  end
                  if (out_ready) void'(q.pop_front());
               end
            end
            vld_d <= out_valid_v[gi];
         end
      end
   end

   task automatic check_idle_outputs(input string tag);
      for (int i = 0; i < 4; i++) begin
         checks++;
         if (in_ready_v[i] !== 1'b1 || out_valid_v[i] !== 1'b0 || s_v[i] !== 16'h0 ||
             cout_v[i] !== 1'b0 || ovf_v[i] !== 1'b0) begin
            errors++;
            $display("FAIL %s inst%0d got rdy=%b vld=%b S=%h C=%b V=%b want 1 0 0000 0 0",
                     tag, i, in_ready_v[i], out_valid_v[i], s_v[i], cout_v[i], ovf_v[i]);
         end
      end
   endtask

   task automatic wait_all_ready();
      int n;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!(&in_ready_v) && n < 400);
      if (!(&in_ready_v)) begin
         checks++;
         errors++;
         $display("FAIL ready_timeout got in_ready=%b want 1111", in_ready_v);
      end
   endtask

   task automatic do_op(input logic [15:0] av, input logic [15:0] bv,
                        input logic sv, input logic cv);
      wait_all_ready();
      in_valid = 1'b1;
      a = av;
      b = bv;
      sub = sv;
      cin = cv;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      a = 16'($urandom);
      b = 16'($urandom);
      sub = 1'($urandom);
      cin = 1'($urandom);
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while ((g[0].q.size() + g[1].q.size() + g[2].q.size() + g[3].q.size()) != 0 && n < 400) begin
         @(posedge clk);
         #1;
         n++;
      end
      wait_all_ready();
   endtask

   initial begin
      repeat (3) @(posedge clk);
      #1;
      check_idle_outputs("reset_state");
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_idle_outputs("after_release");

      do_op(16'h00FF, 16'h0001, 1'b0, 1'b0);
      do_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
      do_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
      do_op(16'h0005, 16'h0007, 1'b1, 1'b0);
      do_op(16'h8000, 16'h0001, 1'b1, 1'b0);
      do_op(16'h00FF, 16'h0000, 1'b0, 1'b1);
      do_op(16'h0000, 16'h0000, 1'b1, 1'b1);
      wait_drain();

      // Backpressure: result held while new operands sit on the input.
      bp_mode = 2;
      do_op(16'h1111, 16'h2222, 1'b0, 1'b0);
      in_valid = 1'b1;
      a = 16'h0F0F;
      b = 16'h0101;
      sub = 1'b1;
      cin = 1'b1;
      repeat (22) @(posedge clk);
      #1;
      bp_mode = 0;
      do_op(16'h0F0F, 16'h0101, 1'b1, 1'b1);
      wait_drain();

      do_op(16'hAAAA, 16'h5555, 1'b0, 1'b1);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #2;
      check_idle_outputs("mid_op_reset");
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_idle_outputs("post_abort");
      do_op(16'h1234, 16'h1111, 1'b0, 1'b0);
      wait_drain();

      bp_mode = 1;
      for (int k = 0; k < 40; k++) begin
         do_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
      end
      do_op(16'h8000, 16'h8000, 1'b0, 1'b0);
      do_op(16'h7FFF, 16'hFFFF, 1'b1, 1'b1);
      bp_mode = 0;
      wait_drain();

      checks++;
      if ((g[0].q.size() + g[1].q.size() + g[2].q.size() + g[3].q.size()) != 0) begin
         errors++;
         $display("FAIL scoreboard_drain got %0d pending want 0",
                  g[0].q.size() + g[1].q.size() + g[2].q.size() + g[3].q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
